// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Package  : video_pkg
// Brief    : Shared constants and types for the raster video datapath:
//            FVHT bit positions, default blanking levels, video word type.
// Revision : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Bit positions inside the {F, V, H, T} timing bus
  localparam int c_fvht_f = 3;
  localparam int c_fvht_v = 2;
  localparam int c_fvht_h = 1;
  localparam int c_fvht_t = 0;

  // Default component width and blanking levels for 4:2:2 video
  localparam int             c_dw      = 10;
  localparam logic [c_dw-1:0] c_blank_y = 10'h040;
  localparam logic [c_dw-1:0] c_blank_c = 10'h200;

  // One video sample: {luma, chroma}
  typedef logic [2*c_dw-1:0] video_word_t;

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_pos_mux_if.sv
`default_nettype none
// ============================================================================
// Interface : video_pos_mux_if
// Brief     : Source/control/result bundle of the position-tracking video mux.
//             master drives sources and settings, slave is the mux itself.
// Revision  : 1.0 - initial release
// ============================================================================
interface video_pos_mux_if
  import video_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DW      = c_dw,
  parameter int CNT_W   = 11
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic                   cen_i;
  logic [SEL_W-1:0]       src_sel_i;
  logic [NUM_SRC*2*DW-1:0] vdat_i;
  logic [3:0]             fvht_i;
  logic                   win_en_i;
  logic [SEL_W-1:0]       win_src_i;
  logic [CNT_W-1:0]       win_x0_i;
  logic [CNT_W-1:0]       win_x1_i;
  logic [CNT_W-1:0]       win_y0_i;
  logic [CNT_W-1:0]       win_y1_i;

  logic [3:0]             fvht_o;
  logic [2*DW-1:0]        video_o;
  logic [CNT_W-1:0]       pix_count_o;
  logic [CNT_W-1:0]       line_count_o;
  logic [CNT_W-1:0]       line_len_o;
  logic [CNT_W-1:0]       frame_lines_o;

  modport master (
    output cen_i, src_sel_i, vdat_i, fvht_i, win_en_i, win_src_i,
           win_x0_i, win_x1_i, win_y0_i, win_y1_i,
    input  fvht_o, video_o, pix_count_o, line_count_o, line_len_o, frame_lines_o
  );

  modport slave (
    input  cen_i, src_sel_i, vdat_i, fvht_i, win_en_i, win_src_i,
           win_x0_i, win_x1_i, win_y0_i, win_y1_i,
    output fvht_o, video_o, pix_count_o, line_count_o, line_len_o, frame_lines_o
  );

endinterface : video_pos_mux_if
`default_nettype wire

// File: rtl/video_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : video_pos_counter
// Brief    : Raster position tracker. Detects H falling / V rising, runs
//            saturating pixel and line counters, exposes the values being
//            loaded this cycle, and measures line length and frame height.
// Revision : 1.0 - initial release
// ============================================================================
module video_pos_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cen_i,
  input  logic             h_i,
  input  logic             v_i,
  output logic             h_fall_o,
  output logic             v_rise_o,
  output logic [CNT_W-1:0] next_pix_o,
  output logic [CNT_W-1:0] next_line_o,
  output logic [CNT_W-1:0] pix_count_o,
  output logic [CNT_W-1:0] line_count_o,
  output logic [CNT_W-1:0] line_len_o,
  output logic [CNT_W-1:0] frame_lines_o
);

  localparam logic [CNT_W-1:0] c_max = '1;
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic             r_h_q;
  logic             r_v_q;
  logic [CNT_W-1:0] r_pix;
  logic [CNT_W-1:0] r_line;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_frames;

  logic             w_h_fall;
  logic             w_v_rise;
  logic [CNT_W-1:0] w_pix_inc;
  logic [CNT_W-1:0] w_line_inc;
  logic [CNT_W-1:0] w_next_pix;
  logic [CNT_W-1:0] w_next_line;

  assign w_h_fall = !h_i && r_h_q;
  assign w_v_rise = v_i && !r_v_q;

  // Saturating increments; pixel+1 also serves as the measured line length
  assign w_pix_inc  = (r_pix  == c_max) ? r_pix  : r_pix  + c_one;
  assign w_line_inc = (r_line == c_max) ? r_line : r_line + c_one;

  // V rising outranks H falling for the line count; pixel restarts on H falling only
  assign w_next_pix  = w_h_fall ? '0 : w_pix_inc;
  assign w_next_line = w_v_rise ? c_one : (w_h_fall ? w_line_inc : r_line);

  // Edge history, counters and measurements advance only on enabled cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_h_q    <= 1'b0;
      r_v_q    <= 1'b0;
      r_pix    <= '0;
      r_line   <= '0;
      r_len    <= '0;
      r_frames <= '0;
    end else if (cen_i) begin
      r_h_q  <= h_i;
      r_v_q  <= v_i;
      r_pix  <= w_next_pix;
      r_line <= w_next_line;
      if (w_h_fall) r_len    <= w_pix_inc;
      if (w_v_rise) r_frames <= r_line;
    end
  end

  assign h_fall_o      = w_h_fall;
  assign v_rise_o      = w_v_rise;
  assign next_pix_o    = w_next_pix;
  assign next_line_o   = w_next_line;
  assign pix_count_o   = r_pix;
  assign line_count_o  = r_line;
  assign line_len_o    = r_len;
  assign frame_lines_o = r_frames;

endmodule : video_pos_counter
`default_nettype wire

// File: rtl/video_pos_mux.sv
`default_nettype none
// ============================================================================
// Module   : video_pos_mux
// Brief    : Selects one of NUM_SRC 4:2:2 sources, overlays a second source
//            inside a frame-latched rectangular window, forces blanking while
//            H or V is high, and reports raster position. One enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module video_pos_mux
  import video_pkg::*;
#(
  parameter int              NUM_SRC = 2,
  parameter int              DW      = c_dw,
  parameter int              CNT_W   = 11,
  parameter logic [DW-1:0]   BLANK_Y = DW'(c_blank_y),
  parameter logic [DW-1:0]   BLANK_C = DW'(c_blank_c)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  video_pos_mux_if.slave bus
);

  localparam int             SEL_W     = $clog2(NUM_SRC);
  localparam int             VW        = 2 * DW;
  localparam int             NUM_PAD   = 1 << SEL_W;
  localparam logic [SEL_W:0] c_num_src = (SEL_W+1)'(NUM_SRC);

  logic             w_h;
  logic             w_v;
  logic             w_h_fall;
  logic             w_v_rise;
  logic [CNT_W-1:0] w_next_pix;
  logic [CNT_W-1:0] w_next_line;
  logic [CNT_W-1:0] w_pix_count;
  logic [CNT_W-1:0] w_line_count;
  logic [CNT_W-1:0] w_line_len;
  logic [CNT_W-1:0] w_frame_lines;

  logic [SEL_W-1:0] r_base_sel;
  logic [SEL_W-1:0] r_win_sel;
  logic             r_win_en;
  logic [CNT_W-1:0] r_x0, r_x1, r_y0, r_y1;

  logic             w_base_ok;
  logic             w_win_ok;
  logic [SEL_W-1:0] w_base_sel;
  logic [SEL_W-1:0] w_win_sel;
  logic             w_win_en;
  logic [CNT_W-1:0] w_x0, w_x1, w_y0, w_y1;
  logic             w_in_win;

  logic [VW-1:0]    w_src [NUM_PAD];
  logic [VW-1:0]    w_video;
  logic [VW-1:0]    r_video;
  logic [3:0]       r_fvht;

  assign w_h = bus.fvht_i[c_fvht_h];
  assign w_v = bus.fvht_i[c_fvht_v];

  video_pos_counter #(
    .CNT_W (CNT_W)
  ) u_pos_counter (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cen_i         (bus.cen_i),
    .h_i           (w_h),
    .v_i           (w_v),
    .h_fall_o      (w_h_fall),
    .v_rise_o      (w_v_rise),
    .next_pix_o    (w_next_pix),
    .next_line_o   (w_next_line),
    .pix_count_o   (w_pix_count),
    .line_count_o  (w_line_count),
    .line_len_o    (w_line_len),
    .frame_lines_o (w_frame_lines)
  );

  // Unpack the source bus; unused select codes read zero but are never selected
  for (genvar k = 0; k < NUM_PAD; k++) begin : g_src
    if (k < NUM_SRC) begin : g_real
      assign w_src[k] = bus.vdat_i[k*VW +: VW];
    end else begin : g_pad
      assign w_src[k] = '0;
    end
  end

  // Out-of-range selects are dropped so the previous frame's choice survives
  assign w_base_ok = {1'b0, bus.src_sel_i} < c_num_src;
  assign w_win_ok  = {1'b0, bus.win_src_i} < c_num_src;

  // On the V-rising sample the new settings already apply, otherwise the shadows
  assign w_base_sel = (w_v_rise && w_base_ok) ? bus.src_sel_i : r_base_sel;
  assign w_win_sel  = (w_v_rise && w_win_ok)  ? bus.win_src_i : r_win_sel;
  assign w_win_en   = w_v_rise ? bus.win_en_i : r_win_en;
  assign w_x0       = w_v_rise ? bus.win_x0_i : r_x0;
  assign w_x1       = w_v_rise ? bus.win_x1_i : r_x1;
  assign w_y0       = w_v_rise ? bus.win_y0_i : r_y0;
  assign w_y1       = w_v_rise ? bus.win_y1_i : r_y1;

  // Inclusive bounds; an inverted pair can never be satisfied
  assign w_in_win = w_win_en &&
                    (w_x0 <= w_next_pix)  && (w_next_pix  <= w_x1) &&
                    (w_y0 <= w_next_line) && (w_next_line <= w_y1);

  // Sample selection: blanking, then overlay, then base source
  always_comb begin
    w_video = w_src[w_base_sel];
    if (w_h || w_v) begin
      w_video = {BLANK_Y, BLANK_C};
    end else if (w_in_win) begin
      w_video = w_src[w_win_sel];
    end
  end

  // Frame-boundary shadow registers for source and window settings
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base_sel <= '0;
      r_win_sel  <= '0;
      r_win_en   <= 1'b0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
    end else if (bus.cen_i && w_v_rise) begin
      r_base_sel <= w_base_sel;
      r_win_sel  <= w_win_sel;
      r_win_en   <= w_win_en;
      r_x0       <= w_x0;
      r_x1       <= w_x1;
      r_y0       <= w_y0;
      r_y1       <= w_y1;
    end
  end

  // Output stage: one enabled cycle of latency for video and timing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_video <= {BLANK_Y, BLANK_C};
      r_fvht  <= 4'b0000;
    end else if (bus.cen_i) begin
      r_video <= w_video;
      r_fvht  <= bus.fvht_i;
    end
  end

  assign bus.video_o       = r_video;
  assign bus.fvht_o        = r_fvht;
  assign bus.pix_count_o   = w_pix_count;
  assign bus.line_count_o  = w_line_count;
  assign bus.line_len_o    = w_line_len;
  assign bus.frame_lines_o = w_frame_lines;

endmodule : video_pos_mux
`default_nettype wire

// File: tb/tb_video_pos_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pos_mux
// Brief    : Self-checking bench for video_pos_mux: reference model feeds a
//            scoreboard queue per driven sample, plus fixed-value spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_pos_mux;
  import video_pkg::*;

  localparam int NUM_SRC = 3;
  localparam int DW      = 10;
  localparam int CNT_W   = 11;
  localparam int MAXC    = (1 << CNT_W) - 1;

  localparam video_word_t c_blank = 20'h10200;
  localparam video_word_t c_s0    = 20'hAAAAA;
  localparam video_word_t c_s1    = 20'h55555;
  localparam video_word_t c_s2    = 20'h12345;

  typedef struct packed {
    video_word_t      vid;
    logic [3:0]       fvht;
    logic [CNT_W-1:0] pix;
    logic [CNT_W-1:0] line;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] frm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  video_pos_mux_if #(.NUM_SRC(NUM_SRC), .DW(DW), .CNT_W(CNT_W)) vif ();

  video_pos_mux #(
    .NUM_SRC (NUM_SRC),
    .DW      (DW),
    .CNT_W   (CNT_W),
    .BLANK_Y (10'h040),
    .BLANK_C (10'h200)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t m_last;
  bit   rand_vdat;

  // Reference model state
  bit m_hq, m_vq, m_wen;
  int m_pix, m_line, m_len, m_frm, m_sel, m_wsrc, m_x0, m_x1, m_y0, m_y1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  // Expected output of the sample currently on the inputs
  task automatic model_push();
    exp_t        e;
    logic [59:0] vd;
    bit          h, v, hf, vr, inwin;
    int          np, nl;
    vd = vif.vdat_i;
    if (rst) begin
      m_hq = 0; m_vq = 0; m_wen = 0;
      m_pix = 0; m_line = 0; m_len = 0; m_frm = 0;
      m_sel = 0; m_wsrc = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
      e = '{vid: c_blank, fvht: 4'h0, pix: '0, line: '0, len: '0, frm: '0};
    end else if (!vif.cen_i) begin
      e = m_last;
    end else begin
      h  = vif.fvht_i[1];
      v  = vif.fvht_i[2];
      hf = !h && m_hq;
      vr = v && !m_vq;
      np = hf ? 0 : sat(m_pix + 1);
      nl = vr ? 1 : (hf ? sat(m_line + 1) : m_line);
      if (hf) m_len = sat(m_pix + 1);
      if (vr) begin
        m_frm = m_line;
        if (int'(vif.src_sel_i) < NUM_SRC) m_sel  = int'(vif.src_sel_i);
        if (int'(vif.win_src_i) < NUM_SRC) m_wsrc = int'(vif.win_src_i);
        m_wen = vif.win_en_i;
        m_x0 = int'(vif.win_x0_i); m_x1 = int'(vif.win_x1_i);
        m_y0 = int'(vif.win_y0_i); m_y1 = int'(vif.win_y1_i);
      end
      inwin = m_wen && (np >= m_x0) && (np <= m_x1) && (nl >= m_y0) && (nl <= m_y1);
      if (h || v)     e.vid = c_blank;
      else if (inwin) e.vid = vd[m_wsrc*20 +: 20];
      else            e.vid = vd[m_sel*20 +: 20];
      e.fvht = vif.fvht_i;
      e.pix  = CNT_W'(np);
      e.line = CNT_W'(nl);
      e.len  = CNT_W'(m_len);
      e.frm  = CNT_W'(m_frm);
      m_pix = np; m_line = nl; m_hq = h; m_vq = v;
    end
    m_last = e;
    sb_q.push_back(e);
  endtask

  // One clock: push expectation, clock it in, pop and compare the outputs
  task automatic tick();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("sb_video", 32'(vif.video_o),       32'(e.vid));
    check_val("sb_fvht",  32'(vif.fvht_o),        32'(e.fvht));
    check_val("sb_pix",   32'(vif.pix_count_o),   32'(e.pix));
    check_val("sb_line",  32'(vif.line_count_o),  32'(e.line));
    check_val("sb_len",   32'(vif.line_len_o),    32'(e.len));
    check_val("sb_frm",   32'(vif.frame_lines_o), 32'(e.frm));
  endtask

  // 16-sample lines (H high on the last 4), 8-line frames (V high on line 0)
  function automatic logic [3:0] raster(input int s, input int l);
    return {1'b0, (l == 0), (s >= 12), (s == 0)};
  endfunction

  task automatic put_sample(input int s, input int l);
    vif.fvht_i = raster(s, l);
    vif.vdat_i = rand_vdat ? 60'({$urandom(), $urandom()}) : {c_s2, c_s1, c_s0};
    vif.cen_i  = 1'b1;
    tick();
  endtask

  // Disabled cycles with garbage on the data and timing inputs
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vif.cen_i  = 1'b0;
      vif.fvht_i = 4'($urandom());
      vif.vdat_i = 60'({$urandom(), $urandom()});
      tick();
    end
  endtask

  task automatic set_win(input bit en, input int src, input int x0, input int x1, input int y0, input int y1);
    vif.win_en_i  = en;
    vif.win_src_i = 2'(src);
    vif.win_x0_i  = CNT_W'(x0);
    vif.win_x1_i  = CNT_W'(x1);
    vif.win_y0_i  = CNT_W'(y0);
    vif.win_y1_i  = CNT_W'(y1);
  endtask

  task automatic do_frame(input int ph, input bit gaps);
    for (int l = 0; l < 8; l++) begin
      for (int s = 0; s < 16; s++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
        if (l == 3 && s == 0) begin
          case (ph)
            3: vif.src_sel_i = 2'd1;
            4: vif.src_sel_i = 2'd3;
            5: begin vif.src_sel_i = 2'd0; set_win(1'b1, 1, 4, 7, 2, 3); end
            6: set_win(1'b1, 1, 4, 14, 2, 3);
            7: set_win(1'b1, 1, 8, 4, 2, 3);
            8: begin vif.src_sel_i = 2'd2; set_win(1'b0, 1, 0, 15, 0, 8); end
            default: ;
          endcase
        end
        put_sample(s, l);
        check_val("pos_pix",  32'(vif.pix_count_o),  32'(s));
        check_val("pos_line", 32'(vif.line_count_o), 32'(l + 1));
        if (s == 0 && !(ph == 0 && l == 0)) check_val("line_len", 32'(vif.line_len_o), 32'd16);
        if (s == 0 && ph >= 1) check_val("frame_lines", 32'(vif.frame_lines_o), 32'd8);
        if (ph == 3 && l == 5 && s == 2) check_val("sel_hold",   32'(vif.video_o), 32'(c_s0));
        if (ph == 4 && l == 1 && s == 0) check_val("sel_new",    32'(vif.video_o), 32'(c_s1));
        if (ph == 5 && l == 1 && s == 0) check_val("sel_bad",    32'(vif.video_o), 32'(c_s1));
        if (ph == 6 && l == 1 && s == 4) check_val("win_x0",     32'(vif.video_o), 32'(c_s1));
        if (ph == 6 && l == 1 && s == 3) check_val("win_left",   32'(vif.video_o), 32'(c_s0));
        if (ph == 6 && l == 2 && s == 7) check_val("win_x1",     32'(vif.video_o), 32'(c_s1));
        if (ph == 6 && l == 2 && s == 8) check_val("win_right",  32'(vif.video_o), 32'(c_s0));
        if (ph == 6 && l == 3 && s == 5) check_val("win_below",  32'(vif.video_o), 32'(c_s0));
        if (ph == 6 && l == 0 && s == 5) check_val("win_vblank", 32'(vif.video_o), 32'(c_blank));
        if (ph == 7 && l == 1 && s == 13) check_val("win_hblank", 32'(vif.video_o), 32'(c_blank));
        if (ph == 7 && l == 1 && s == 11) check_val("win_wide",   32'(vif.video_o), 32'(c_s1));
        if (ph == 8 && l == 1 && s == 6) check_val("win_empty",  32'(vif.video_o), 32'(c_s0));
        if (ph == 8 && l == 2 && s == 5) check_val("win_empty2", 32'(vif.video_o), 32'(c_s0));
        if (ph == 9 && l == 1 && s == 6) check_val("sel_src2",   32'(vif.video_o), 32'(c_s2));
      end
    end
  endtask

  initial begin
    vif.cen_i     = 1'b0;
    vif.src_sel_i = '0;
    vif.vdat_i    = '0;
    vif.fvht_i    = 4'h0;
    set_win(1'b0, 0, 0, 0, 0, 0);
    rand_vdat     = 1'b1;

    // Reset wins over a low clock enable
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_video", 32'(vif.video_o),      32'h10200);
    check_val("rst_pix",   32'(vif.pix_count_o),  32'd0);
    check_val("rst_line",  32'(vif.line_count_o), 32'd0);

    // Outputs hold while disabled
    idle(10);
    check_val("hold_video", 32'(vif.video_o),     32'h10200);
    check_val("hold_pix",   32'(vif.pix_count_o), 32'd0);

    // Counting frames, the last with random enable gaps
    for (int s = 12; s < 16; s++) put_sample(s, 7);
    do_frame(0, 1'b0);
    do_frame(1, 1'b0);
    do_frame(2, 1'b1);

    // Frame-aligned select and window overlay with fixed source words
    rand_vdat = 1'b0;
    for (int ph = 3; ph <= 9; ph++) do_frame(ph, 1'b0);

    // Pixel counter saturation on an endless line
    vif.fvht_i = 4'h0;
    for (int i = 0; i < MAXC + 6; i++) tick();
    check_val("sat_pix", 32'(vif.pix_count_o), 32'h7FF);
    vif.fvht_i = 4'b0010;
    tick();
    tick();
    check_val("sat_hold", 32'(vif.pix_count_o), 32'h7FF);
    vif.fvht_i = 4'h0;
    tick();
    check_val("sat_len", 32'(vif.line_len_o),  32'h7FF);
    check_val("sat_pix0", 32'(vif.pix_count_o), 32'd0);

    // Reset in the middle of an active line
    for (int s = 12; s < 16; s++) put_sample(s, 7);
    for (int s = 0; s < 6; s++) put_sample(s, 1);
    rst = 1'b1;
    put_sample(6, 1);
    rst = 1'b0;
    for (int s = 7; s < 16; s++) put_sample(s, 1);
    put_sample(0, 2);
    check_val("mid_rst_line", 32'(vif.line_count_o), 32'd1);
    check_val("mid_rst_pix",  32'(vif.pix_count_o),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_video_pos_mux
`default_nettype wire
